// File: rtl/cycle_controller_pkg.sv
// cycle_controller_pkg: phase names, opcodes, datapath select encodings and fetch states shared by the controller.
package cycle_controller_pkg;
  localparam logic [2:0] PH_A1 = 3'd0, PH_A2 = 3'd1, PH_A3 = 3'd2, PH_M1 = 3'd3;
  localparam logic [2:0] PH_M2 = 3'd4, PH_X1 = 3'd5, PH_X2 = 3'd6, PH_X3 = 3'd7;
  localparam logic [2:0] WRITE_PHASE = PH_X2;
  localparam logic [2:0] SYNC_PHASE = PH_X3;
  localparam logic [3:0] OPR_JCN = 4'h1, OPR_JUN = 4'h4, OPR_INC = 4'h6, OPR_ISZ = 4'h7;
  localparam logic [3:0] OPR_ADD = 4'h8, OPR_SUB = 4'h9, OPR_LD = 4'hA, OPR_XCH = 4'hB;
  localparam logic [3:0] OPR_LDM = 4'hD, OPR_GRP_F = 4'hF;
  localparam logic [3:0] OPA_CLB = 4'h0, OPA_CLC = 4'h1, OPA_IAC = 4'h2, OPA_CMC = 4'h3;
  localparam logic [3:0] OPA_CMA = 4'h4, OPA_TCC = 4'h7, OPA_TCS = 4'h9;
  localparam logic [2:0] ACC_IN_FROM_ALU = 3'd0, ACC_IN_FROM_REG = 3'd1, ACC_IN_FROM_IMM = 3'd2;
  localparam logic [2:0] ACC_IN_FROM_CARRY = 3'd3, ACC_IN_FROM_TCS = 3'd4;
  localparam logic [1:0] REG_IN_FROM_ACC = 2'd0, REG_IN_FROM_ALU = 2'd1;
  // ALU_OP_NOT yields ~in0 with carry-out = carry-in, so CMC is NOT with an inverted carry-in
  localparam logic [2:0] ALU_OP_ADD = 3'd0, ALU_OP_NOT = 3'd1;
  localparam logic [2:0] ALU_IN0_ACC = 3'd0, ALU_IN0_REG = 3'd1, ALU_IN0_ZERO = 3'd2;
  localparam logic [1:0] ALU_IN1_REG = 2'd0, ALU_IN1_NOT_REG = 2'd1, ALU_IN1_ZERO = 2'd2;
  localparam logic [1:0] ALU_CIN_CARRY = 2'd0, ALU_CIN_NOT_CARRY = 2'd1, ALU_CIN_ZERO = 2'd2, ALU_CIN_ONE = 2'd3;
  typedef enum logic {FETCH1, FETCH2} fetch_state_e;
endpackage

// File: rtl/cycle_controller_inst_decoder.sv
// inst_decoder: combinational OPR/OPA decode into datapath selects, write/clear intents, is_two_word and unimpl.
//   in : opr, opa (latched opcode nibbles), second (executing the second word of a 2-word op)
//   out: *_sel / alu_op selects, wr_*/clr_* intents (ungated by phase), two_word, unimpl
module inst_decoder
  import cycle_controller_pkg::*;
(
  input  logic [3:0] opr,
  input  logic [3:0] opa,
  input  logic       second,
  output logic [2:0] acc_sel,
  output logic [1:0] reg_sel,
  output logic [2:0] alu_op,
  output logic [2:0] in0_sel,
  output logic [1:0] in1_sel,
  output logic [1:0] cin_sel,
  output logic       clr_c,
  output logic       wr_c,
  output logic       clr_acc,
  output logic       wr_acc,
  output logic       wr_reg,
  output logic       two_word,
  output logic       unimpl
);
  always_comb begin
    acc_sel = ACC_IN_FROM_ALU;
    reg_sel = REG_IN_FROM_ACC;
    alu_op = ALU_OP_ADD;
    in0_sel = ALU_IN0_ACC;
    in1_sel = ALU_IN1_REG;
    cin_sel = ALU_CIN_CARRY;
    {clr_c, wr_c, clr_acc, wr_acc, wr_reg} = '0;
    unimpl = 1'b0;
    two_word = opr inside {OPR_JCN, OPR_JUN, OPR_ISZ};
    case (opr)
      OPR_JCN, OPR_JUN: ;
      OPR_INC, OPR_ISZ: begin
        in0_sel = ALU_IN0_REG;
        in1_sel = ALU_IN1_ZERO;
        cin_sel = ALU_CIN_ONE;
        reg_sel = REG_IN_FROM_ALU;
        // ISZ increments only in its second cycle, where the skip test follows
        wr_reg = (opr == OPR_INC) ? 1'b1 : second;
      end
      OPR_ADD: {wr_acc, wr_c} = 2'b11;
      OPR_SUB: begin
        in1_sel = ALU_IN1_NOT_REG;
        cin_sel = ALU_CIN_NOT_CARRY;
        {wr_acc, wr_c} = 2'b11;
      end
      OPR_LD: begin
        acc_sel = ACC_IN_FROM_REG;
        wr_acc = 1'b1;
      end
      OPR_XCH: begin
        acc_sel = ACC_IN_FROM_REG;
        reg_sel = REG_IN_FROM_ACC;
        {wr_acc, wr_reg} = 2'b11;
      end
      OPR_LDM: begin
        acc_sel = ACC_IN_FROM_IMM;
        wr_acc = 1'b1;
      end
      OPR_GRP_F:
        case (opa)
          OPA_CLB: {clr_acc, clr_c} = 2'b11;
          OPA_CLC: clr_c = 1'b1;
          OPA_IAC: begin
            in1_sel = ALU_IN1_ZERO;
            cin_sel = ALU_CIN_ONE;
            {wr_acc, wr_c} = 2'b11;
          end
          OPA_CMC: begin
            alu_op = ALU_OP_NOT;
            cin_sel = ALU_CIN_NOT_CARRY;
            wr_c = 1'b1;
          end
          OPA_CMA: begin
            alu_op = ALU_OP_NOT;
            wr_acc = 1'b1;
          end
          OPA_TCC: begin
            acc_sel = ACC_IN_FROM_CARRY;
            {wr_acc, clr_c} = 2'b11;
          end
          OPA_TCS: begin
            acc_sel = ACC_IN_FROM_TCS;
            {wr_acc, clr_c} = 2'b11;
          end
          default: unimpl = 1'b1;
        endcase
      default: unimpl = 1'b1;
    endcase
  end
endmodule

// File: rtl/cycle_controller.sv
// cycle_controller: 8-phase machine-cycle sequencer; latches OPR/OPA, runs the FETCH1/FETCH2 FSM, drives datapath strobes and PC pulses.
//   in : clock, reset_n (async active-low), data (bus nibble), take_branch, reg_is_zero
//   out: phase, sync, pc_advance, pc_load, jump_addr, inst_operand, write/clear strobes, selects, unimpl
//   CTRL_STEP_EN: adds step input and halted output for single-instruction stepping
module cycle_controller
  import cycle_controller_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] data,
  input  logic       take_branch,
  input  logic       reg_is_zero,
`ifdef CTRL_STEP_EN
  input  logic       step,
  output logic       halted,
`endif
  output logic [2:0] phase,
  output logic       sync,
  output logic       pc_advance,
  output logic       pc_load,
  output logic [7:0] jump_addr,
  output logic [3:0] inst_operand,
  output logic       clear_carry,
  output logic       write_carry,
  output logic       clear_accumulator,
  output logic       write_accumulator,
  output logic       write_register,
  output logic [2:0] acc_input_sel,
  output logic [1:0] reg_input_sel,
  output logic [2:0] alu_op,
  output logic [2:0] alu_in0_sel,
  output logic [1:0] alu_in1_sel,
  output logic [1:0] alu_cin_sel,
  output logic       unimpl
);
  fetch_state_e state, state_nx;
  logic [3:0] opr, opa;
  logic adv, x_ph, w_ph, s_ph;
  logic [2:0] d_acc_sel, d_alu_op, d_in0_sel;
  logic [1:0] d_reg_sel, d_in1_sel, d_cin_sel;
  logic d_clr_c, d_wr_c, d_clr_acc, d_wr_acc, d_wr_reg, d_two_word, d_unimpl;

  inst_decoder u_dec (
    .opr(opr), .opa(opa), .second(state == FETCH2),
    .acc_sel(d_acc_sel), .reg_sel(d_reg_sel), .alu_op(d_alu_op),
    .in0_sel(d_in0_sel), .in1_sel(d_in1_sel), .cin_sel(d_cin_sel),
    .clr_c(d_clr_c), .wr_c(d_wr_c), .clr_acc(d_clr_acc), .wr_acc(d_wr_acc), .wr_reg(d_wr_reg),
    .two_word(d_two_word), .unimpl(d_unimpl)
  );

`ifdef CTRL_STEP_EN
  // parked at A1 of a fresh instruction until step is seen high
  assign halted = (state == FETCH1) && (phase == PH_A1);
  assign adv = !halted || step;
`else
  assign adv = 1'b1;
`endif

  assign x_ph = phase >= PH_X1;
  assign w_ph = phase == WRITE_PHASE;
  assign s_ph = phase == SYNC_PHASE;
  assign inst_operand = opa;

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      phase <= PH_A1;
      state <= FETCH1;
      opr <= '0;
      opa <= '0;
      jump_addr <= '0;
    end else begin
      state <= state_nx;
      if (adv) phase <= phase + 3'd1;
      // the second word goes to jump_addr so the first word's OPR/OPA stay decodable
      if (phase == PH_M1 && state == FETCH1) opr <= data;
      if (phase == PH_M2 && state == FETCH1) opa <= data;
      if (phase == PH_M1 && state == FETCH2) jump_addr[7:4] <= data;
      if (phase == PH_M2 && state == FETCH2) jump_addr[3:0] <= data;
    end

  always_comb begin
    state_nx = state;
    if (s_ph) state_nx = (state == FETCH1 && d_two_word) ? FETCH2 : FETCH1;
    sync = s_ph;
    pc_advance = phase == PH_A3;
    pc_load = s_ph && state == FETCH2 &&
              (opr == OPR_JUN || (opr == OPR_JCN && take_branch) || (opr == OPR_ISZ && !reg_is_zero));
    unimpl = s_ph && state == FETCH1 && d_unimpl;
    acc_input_sel = x_ph ? d_acc_sel : '0;
    reg_input_sel = x_ph ? d_reg_sel : '0;
    alu_op = x_ph ? d_alu_op : '0;
    alu_in0_sel = x_ph ? d_in0_sel : '0;
    alu_in1_sel = x_ph ? d_in1_sel : '0;
    alu_cin_sel = x_ph ? d_cin_sel : '0;
    clear_carry = w_ph && d_clr_c;
    write_carry = w_ph && d_wr_c;
    clear_accumulator = w_ph && d_clr_acc;
    write_accumulator = w_ph && d_wr_acc;
    write_register = w_ph && d_wr_reg;
  end
endmodule
